dcache_store_commit_buffer: RTL and testbench
=============================================

# dcache_store_commit_buffer

Committed-store FIFO that sits directly upstream of the L1 data cache write port. It accepts stores retired by the LSU commit logic, holds them in program order, and drains them one per cycle into the cache's store interface (enable, address, data, size). It retries any store that misses, and backs off while the cache raises its store-commit stall. It also reports load-address conflicts with buffered stores, so the load path can replay instead of reading stale data.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_W, 64, store/load virtual address width (`SIZE_VIRT_ADDR`)
- DATA_W, 64, store data width (`SIZE_DATA`)
- SZ_W, 2, size-code width (`LDST_TYPES_LOG`)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- stValid_i  in  1  committed store offered
- stAddr_i  in  ADDR_W  store byte address
- stData_i  in  DATA_W  store data, LSB-aligned
- stSize_i  in  SZ_W  `LDST_BYTE`/`HALF_WORD`/`WORD`/`DOUBLE_WORD` code, passed through
- stReady_o  out  1  buffer can accept this cycle
- dcWrEn_o  out  1  head store presented to cache
- dcWrAddr_o  out  ADDR_W  head address
- dcWrData_o  out  DATA_W  head data
- dcStSize_o  out  SZ_W  head size
- dcWrHit_i  in  1  cache accepted presented store (same cycle as dcWrEn_o)
- dcStall_i  in  1  cache store-commit stall
- ldEn_i  in  1  load probe valid
- ldAddr_i  in  ADDR_W  load byte address
- ldConflict_o  out  1  load overlaps a buffered store's doubleword
- drainReq_i  in  1  request full drain (fence / flush)
- empty_o  out  1  no valid entries
- count_o  out  log2(DEPTH)+1  valid-entry count

## Operation
- Storage: circular array of DEPTH entries {addr, data, size}. Head/tail pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- Push: occurs when stValid_i & stReady_o; writes at tail, tail+1. stValid_i without stReady_o: store is not captured; the upstream stage holds it.
- stReady_o = reset & (count < DEPTH) & ~drainMode. A full buffer does not accept a push even when a pop occurs in the same cycle.
- Present: dcWrEn_o = (count ≠ 0) & ~dcStall_i. dcWrAddr_o, dcWrData_o and dcStSize_o always reflect the head entry (zero when empty).
- Pop: occurs when dcWrEn_o & dcWrHit_i; head+1. With dcWrEn_o & ~dcWrHit_i (miss), the head stays put and is re-presented every following non-stalled cycle until it hits. No reordering or merging.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Conflict: ldConflict_o = ldEn_i & OR over valid entries of (entry.addr[ADDR_W-1:3] == ldAddr_i[ADDR_W-1:3]). This is combinational over registered state. The entry popped this cycle still counts. A store being pushed this cycle does not.
- Drain FSM has two states:
  - IDLE: drainReq_i → DRAIN.
  - DRAIN: stReady_o = 0, popping continues normally. When count == 0 → IDLE.
  - drainReq_i in IDLE with count == 0 still enters DRAIN for one cycle.
- empty_o = (count == 0).
- Reset (reset low at a clock edge):
  - head, tail and count cleared, FSM → IDLE.
  - Buffered stores are discarded, including mid-drain and mid-retry.
  - While reset is low: stReady_o = 0, dcWrEn_o = 0, ldConflict_o = 0, empty_o = 1, count_o = 0, dc* data outputs = 0.
- Pipeline recovery does not affect the buffer; contents are already committed.

## Timing
- Push→present latency: a store pushed at edge N is visible on dcWr* in cycle N+1 (earliest cache write).
- Throughput: one push and one pop per cycle.
- A store that hits on first presentation is resident for 1 cycle.
- A miss adds ≥1 cycle per retry. dcStall_i cycles add 1 each.
- stReady_o, count_o and empty_o are registered-state derived and update the cycle after the push or pop.
- DRAIN entry: stReady_o falls in the cycle after drainReq_i is sampled. It returns to 1 in the cycle after the last pop.

## Test plan
- Reset then single store: addr 0x1008, data 0xAB, size BYTE.
  - dcWrEn_o = 1 next cycle with matching fields.
  - dcWrHit_i = 1 → empty_o = 1 the following cycle.
- Fill: push 8 stores with dcStall_i = 1.
  - count_o = 8, stReady_o = 0.
  - A 9th offer is not captured.
  - Release stall with hit every cycle → 8 pops in order over 8 cycles, then empty.
- Miss retry: head store dcWrHit_i = 0 for 3 presentations, then 1.
  - Same addr/data presented 4 times; count decrements once.
- Simultaneous push and pop at count = 3: count stays 3; FIFO order preserved across head/tail wrap (push 12 stores total).
- Conflict and drain: buffered store at 0x2004.
  - ldAddr_i = 0x2000 → ldConflict_o = 1; 0x2008 → 0.
  - drainReq_i → stReady_o = 0 until empty, then 1.
- Reset mid-retry with 5 entries → count_o = 0, dcWrEn_o = 0 on the next cycle.

Source files
------------

// File: rtl/dcache_store_commit_buffer.sv
// Committed-store FIFO feeding the L1 data cache write port.
// Drains in program order, retries misses, honours cache stall, flags load conflicts.
module dcache_store_commit_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SZ_W   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stValid_i,
  input  logic [ADDR_W-1:0]             stAddr_i,
  input  logic [DATA_W-1:0]             stData_i,
  input  logic [SZ_W-1:0]               stSize_i,
  output logic                          stReady_o,
  output logic                          dcWrEn_o,
  output logic [ADDR_W-1:0]             dcWrAddr_o,
  output logic [DATA_W-1:0]             dcWrData_o,
  output logic [SZ_W-1:0]               dcStSize_o,
  input  logic                          dcWrHit_i,
  input  logic                          dcStall_i,
  input  logic                          ldEn_i,
  input  logic [ADDR_W-1:0]             ldAddr_i,
  output logic                          ldConflict_o,
  input  logic                          drainReq_i,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [SZ_W-1:0]    size_mem [DEPTH];

  logic               not_empty;
  logic               st_ready;
  logic               wr_en;
  logic               push;
  logic               pop;
  logic               conflict;
  logic [PTR_W-1:0]   offset;

  // Byte offset within the doubleword is irrelevant to conflict detection.
  logic               unused_ld_lsbs;
  assign unused_ld_lsbs = ^ldAddr_i[2:0];

  // Handshake and presentation, all derived from registered state and gated by reset.
  always_comb begin
    not_empty = 1'b0;
    st_ready  = 1'b0;
    wr_en     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    not_empty = (count_q != '0);
    st_ready  = reset && (count_q < CNT_W'(DEPTH)) && (state_q == ST_IDLE);
    wr_en     = reset && not_empty && !dcStall_i;
    push      = stValid_i && st_ready;
    pop       = wr_en && dcWrHit_i;
  end

  // Any valid entry (including the one popping now) sharing the load's doubleword.
  always_comb begin
    conflict = 1'b0;
    offset   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (({1'b0, offset} < count_q) &&
          (addr_mem[i][ADDR_W-1:3] == ldAddr_i[ADDR_W-1:3])) begin
        conflict = 1'b1;
      end
    end
  end

  // Pointer, occupancy and drain-mode next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;

    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Leave drain as soon as the last pop lands so acceptance resumes the next cycle.
    case (state_q)
      ST_IDLE: begin
        if (drainReq_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity is tracked purely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= stAddr_i;
      data_mem[tail_q] <= stData_i;
      size_mem[tail_q] <= stSize_i;
    end
  end

  always_comb begin
    stReady_o    = st_ready;
    dcWrEn_o     = wr_en;
    dcWrAddr_o   = '0;
    dcWrData_o   = '0;
    dcStSize_o   = '0;
    ldConflict_o = reset && ldEn_i && conflict;
    empty_o      = !(reset && not_empty);
    count_o      = reset ? count_q : '0;
    if (reset && not_empty) begin
      dcWrAddr_o = addr_mem[head_q];
      dcWrData_o = data_mem[head_q];
      dcStSize_o = size_mem[head_q];
    end
  end

endmodule

// File: tb/tb_dcache_store_commit_buffer.sv
// Directed self-checking bench for dcache_store_commit_buffer.
module tb_dcache_store_commit_buffer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SZ_W   = 2;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              stValid_i;
  logic [ADDR_W-1:0] stAddr_i;
  logic [DATA_W-1:0] stData_i;
  logic [SZ_W-1:0]   stSize_i;
  logic              stReady_o;
  logic              dcWrEn_o;
  logic [ADDR_W-1:0] dcWrAddr_o;
  logic [DATA_W-1:0] dcWrData_o;
  logic [SZ_W-1:0]   dcStSize_o;
  logic              dcWrHit_i;
  logic              dcStall_i;
  logic              ldEn_i;
  logic [ADDR_W-1:0] ldAddr_i;
  logic              ldConflict_o;
  logic              drainReq_i;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;

  int vectors     = 0;
  int miscompares = 0;

  dcache_store_commit_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SZ_W  (SZ_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stValid_i   (stValid_i),
    .stAddr_i    (stAddr_i),
    .stData_i    (stData_i),
    .stSize_i    (stSize_i),
    .stReady_o   (stReady_o),
    .dcWrEn_o    (dcWrEn_o),
    .dcWrAddr_o  (dcWrAddr_o),
    .dcWrData_o  (dcWrData_o),
    .dcStSize_o  (dcStSize_o),
    .dcWrHit_i   (dcWrHit_i),
    .dcStall_i   (dcStall_i),
    .ldEn_i      (ldEn_i),
    .ldAddr_i    (ldAddr_i),
    .ldConflict_o(ldConflict_o),
    .drainReq_i  (drainReq_i),
    .empty_o     (empty_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    stValid_i = 1'b1;
    stAddr_i  = a;
    stData_i  = d;
    stSize_i  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stValid_i = 1'b0; stAddr_i = '0; stData_i = '0; stSize_i = '0;
    dcWrHit_i = 1'b0; dcStall_i = 1'b0; ldEn_i = 1'b0; ldAddr_i = '0; drainReq_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 64'(stReady_o), 64'd0);
    chk("rst_wren",  64'(dcWrEn_o),  64'd0);
    chk("rst_empty", 64'(empty_o),   64'd1);
    chk("rst_count", 64'(count_o),   64'd0);
    chk("rst_addr",  dcWrAddr_o,     64'd0);
    reset = 1'b1;
    #1;
    chk("idle_ready", 64'(stReady_o), 64'd1);
    chk("idle_wren",  64'(dcWrEn_o),  64'd0);

    // Single store, presented the next cycle, hit empties it
    offer(64'h1008, 64'hAB, 2'd0);
    tick();
    stValid_i = 1'b0; dcWrHit_i = 1'b1;
    #1;
    chk("single_wren", 64'(dcWrEn_o),   64'd1);
    chk("single_addr", dcWrAddr_o,      64'h1008);
    chk("single_data", dcWrData_o,      64'hAB);
    chk("single_size", 64'(dcStSize_o), 64'd0);
    chk("single_cnt",  64'(count_o),    64'd1);
    tick();
    dcWrHit_i = 1'b0;
    chk("single_empty", 64'(empty_o),  64'd1);
    chk("single_wren0", 64'(dcWrEn_o), 64'd0);

    // Fill under stall
    dcStall_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(64'h100 + 64'(i * 8), 64'hD0 + 64'(i), 2'(i));
      tick();
    end
    stValid_i = 1'b0;
    #1;
    chk("fill_cnt",   64'(count_o),   64'd8);
    chk("fill_ready", 64'(stReady_o), 64'd0);
    chk("fill_stall", 64'(dcWrEn_o),  64'd0);
    offer(64'h999, 64'h99, 2'd3);
    tick();
    stValid_i = 1'b0;
    chk("fill_9th_cnt", 64'(count_o), 64'd8);
    dcStall_i = 1'b0; dcWrHit_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_addr", dcWrAddr_o,      64'h100 + 64'(i * 8));
      chk("drain_data", dcWrData_o,      64'hD0 + 64'(i));
      chk("drain_size", 64'(dcStSize_o), 64'(i % 4));
      chk("drain_cnt",  64'(count_o),    64'(8 - i));
      tick();
    end
    dcWrHit_i = 1'b0;
    chk("drain_empty", 64'(empty_o), 64'd1);

    // Miss retry: three misses then a hit
    dcStall_i = 1'b1;
    offer(64'h3000, 64'h11, 2'd3); tick();
    offer(64'h3008, 64'h22, 2'd3); tick();
    stValid_i = 1'b0; dcStall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_wren", 64'(dcWrEn_o), 64'd1);
      chk("miss_addr", dcWrAddr_o,    64'h3000);
      chk("miss_data", dcWrData_o,    64'h11);
      tick();
      chk("miss_cnt",  64'(count_o),  64'd2);
    end
    dcWrHit_i = 1'b1;
    #1;
    chk("hit_addr", dcWrAddr_o, 64'h3000);
    tick();
    dcWrHit_i = 1'b0;
    chk("hit_cnt",  64'(count_o), 64'd1);
    chk("hit_next", dcWrAddr_o,   64'h3008);
    dcWrHit_i = 1'b1;
    tick();
    dcWrHit_i = 1'b0;
    chk("miss_empty", 64'(empty_o), 64'd1);

    // Simultaneous push/pop at count 3 across pointer wrap
    dcStall_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      offer(64'h4000 + 64'(j * 8), 64'hC0DE_0000 + 64'(j), 2'd2);
      tick();
    end
    dcStall_i = 1'b0; dcWrHit_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      offer(64'h4000 + 64'((k + 3) * 8), 64'hC0DE_0000 + 64'(k + 3), 2'd2);
      #1;
      chk("pp_addr", dcWrAddr_o,   64'h4000 + 64'(k * 8));
      chk("pp_data", dcWrData_o,   64'hC0DE_0000 + 64'(k));
      chk("pp_cnt",  64'(count_o), 64'd3);
      tick();
    end
    stValid_i = 1'b0;
    for (int k = 9; k < 12; k++) begin
      #1;
      chk("pp_tail_addr", dcWrAddr_o,   64'h4000 + 64'(k * 8));
      chk("pp_tail_cnt",  64'(count_o), 64'(12 - k));
      tick();
    end
    dcWrHit_i = 1'b0;
    chk("pp_empty", 64'(empty_o), 64'd1);

    // Load conflicts against buffered stores
    dcStall_i = 1'b1;
    offer(64'h2004, 64'h55, 2'd2); tick();
    offer(64'h3010, 64'h66, 2'd3); tick();
    stValid_i = 1'b0;
    ldEn_i = 1'b1; ldAddr_i = 64'h2000; #1;
    chk("conf_2000", 64'(ldConflict_o), 64'd1);
    ldAddr_i = 64'h2008; #1;
    chk("conf_2008", 64'(ldConflict_o), 64'd0);
    ldAddr_i = 64'h3017; #1;
    chk("conf_3017", 64'(ldConflict_o), 64'd1);
    ldEn_i = 1'b0; ldAddr_i = 64'h2000; #1;
    chk("conf_noen", 64'(ldConflict_o), 64'd0);
    offer(64'h5000, 64'h77, 2'd3);
    ldEn_i = 1'b1; ldAddr_i = 64'h5000; #1;
    chk("conf_pushing", 64'(ldConflict_o), 64'd0);
    tick();
    stValid_i = 1'b0;
    chk("conf_pushed", 64'(ldConflict_o), 64'd1);
    ldEn_i = 1'b0;

    // Drain request blocks acceptance until the buffer empties
    drainReq_i = 1'b1; #1;
    chk("drn_ready_pre", 64'(stReady_o), 64'd1);
    tick();
    drainReq_i = 1'b0; #1;
    chk("drn_ready0", 64'(stReady_o), 64'd0);
    chk("drn_cnt3",   64'(count_o),   64'd3);
    dcStall_i = 1'b0; dcWrHit_i = 1'b1; #1;
    chk("drn_addr", dcWrAddr_o, 64'h2004);
    tick();
    chk("drn_cnt2",   64'(count_o),   64'd2);
    chk("drn_ready1", 64'(stReady_o), 64'd0);
    offer(64'h6000, 64'h88, 2'd3);
    tick();
    stValid_i = 1'b0;
    chk("drn_cnt1",   64'(count_o),   64'd1);
    chk("drn_ready2", 64'(stReady_o), 64'd0);
    chk("drn_head",   dcWrAddr_o,     64'h5000);
    tick();
    dcWrHit_i = 1'b0;
    chk("drn_done_cnt",   64'(count_o),   64'd0);
    chk("drn_done_ready", 64'(stReady_o), 64'd1);
    chk("drn_done_empty", 64'(empty_o),   64'd1);

    // Drain request while already empty: one cycle of drain mode
    drainReq_i = 1'b1;
    tick();
    drainReq_i = 1'b0; #1;
    chk("edrn_ready0", 64'(stReady_o), 64'd0);
    tick();
    chk("edrn_ready1", 64'(stReady_o), 64'd1);

    // Reset in the middle of a miss retry with five entries
    dcStall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer(64'h7000 + 64'(k * 8), 64'hE0 + 64'(k), 2'd3);
      tick();
    end
    stValid_i = 1'b0; dcStall_i = 1'b0; #1;
    chk("mr_cnt",  64'(count_o),  64'd5);
    chk("mr_wren", 64'(dcWrEn_o), 64'd1);
    tick();
    chk("mr_cnt2", 64'(count_o), 64'd5);
    chk("mr_addr", dcWrAddr_o,   64'h7000);
    ldEn_i = 1'b1; ldAddr_i = 64'h7000;
    reset = 1'b0; #1;
    chk("mr_rst_ready", 64'(stReady_o),    64'd0);
    chk("mr_rst_wren",  64'(dcWrEn_o),     64'd0);
    chk("mr_rst_cnt",   64'(count_o),      64'd0);
    chk("mr_rst_empty", 64'(empty_o),      64'd1);
    chk("mr_rst_conf",  64'(ldConflict_o), 64'd0);
    chk("mr_rst_data",  dcWrData_o,        64'd0);
    tick();
    reset = 1'b1; #1;
    chk("post_cnt",   64'(count_o),      64'd0);
    chk("post_wren",  64'(dcWrEn_o),     64'd0);
    chk("post_empty", 64'(empty_o),      64'd1);
    chk("post_conf",  64'(ldConflict_o), 64'd0);
    chk("post_ready", 64'(stReady_o),    64'd1);
    ldEn_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
